instr_encoder_loader: RTL and testbench

//  Opposite direction of the instruction decoder: accepts decoded instruction fields over a valid/ready stream,

---
 rtl/isa_pkg.sv | 70 +++++++
 rtl/instr_pack.sv | 40 ++++
 rtl/instr_encoder_loader.sv | 134 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: opcodes, formats,
// bit positions of every field in the 16-bit word, and the legality rule.
package isa_pkg;

  localparam int WORD_W    = 16;
  localparam int OPC_LSB   = 12;
  localparam int OPC_W     = 4;
  localparam int REG_W     = 3;
  localparam int RD_LSB    = 9;
  localparam int RS1_LSB   = 6;
  localparam int RS2_LSB   = 3;
  localparam int NZIMM_LSB = 0;
  localparam int NZIMM_W   = 6;
  localparam int IMM7_LSB  = 2;
  localparam int IMM7_W    = 7;
  localparam int BASE_LSB  = 0;
  localparam int BASE_W    = 2;
  localparam int OFF_LSB   = 0;
  localparam int OFF_W     = 9;
  localparam int IMM_IN_W  = 9;

  typedef enum logic [3:0] {
    OP_LW   = 4'b0000,
    OP_SW   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_ADDI = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_LB   = 4'b0101,
    OP_AND  = 4'b0110,
    OP_OR   = 4'b0111,
    OP_SLLI = 4'b1000,
    OP_SRLI = 4'b1001,
    OP_BR0  = 4'b1010,
    OP_BR1  = 4'b1011
  } opcode_e;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I6,
    FMT_I7,
    FMT_B
  } format_e;

  // Opcodes above OP_BR1 have no format; they fall back to FMT_R and are
  // rejected by is_legal before anything is written.
  function automatic format_e get_format(input logic [OPC_W-1:0] op);
    format_e fmt;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: fmt = FMT_R;
      OP_ADDI, OP_SLLI, OP_SRLI:     fmt = FMT_I6;
      OP_LW, OP_SW, OP_LB:           fmt = FMT_I7;
      OP_BR0, OP_BR1:                fmt = FMT_B;
      default:                       fmt = FMT_R;
    endcase
    return fmt;
  endfunction

  function automatic logic is_legal(input logic [OPC_W-1:0] op,
                                    input logic [IMM_IN_W-1:0] imm);
    logic ok;
    ok = 1'b1;
    if (op > OP_BR1) begin
      ok = 1'b0;
    end else if (get_format(op) == FMT_I6 && imm[NZIMM_W-1:0] == '0) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded instruction fields -> 16-bit instruction word
// plus a legal flag. Field bits not used by the selected format are ignored.
module instr_pack
  import isa_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [IMM_IN_W-1:0] imm,
  output logic [WORD_W-1:0]   word,
  output logic                legal
);

  always_comb begin
    word = '0;
    word[OPC_LSB +: OPC_W] = opcode;
    word[RD_LSB +: REG_W]  = rd;
    case (get_format(opcode))
      FMT_R: begin
        word[RS1_LSB +: REG_W] = rs1;
        word[RS2_LSB +: REG_W] = rs2;
      end
      FMT_I6: begin
        word[RS1_LSB +: REG_W]     = rs1;
        word[NZIMM_LSB +: NZIMM_W] = imm[NZIMM_W-1:0];
      end
      FMT_I7: begin
        word[IMM7_LSB +: IMM7_W] = imm[IMM7_W-1:0];
        word[BASE_LSB +: BASE_W] = rs1[BASE_W-1:0];
      end
      FMT_B: begin
        word[OFF_LSB +: OFF_W] = imm[OFF_W-1:0];
      end
      default: ;
    endcase
    legal = is_legal(opcode, imm);
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: packs decoded fields and writes them sequentially into imem.
// Optional post-write readback verification is enabled by ENCODER_READBACK_EN.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rs2,
  input  logic [IMM_IN_W-1:0] in_imm,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  input  logic [WORD_W-1:0]   imem_rdata,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                err_illegal,
  output logic                err_mismatch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RB_ADDR,
    S_RB_CMP,
    S_FULL
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  state_e              state;
  logic [WORD_W-1:0]   packed_word;
  logic                packed_legal;
  logic [ADDR_W:0]     count_inc;
  logic                accept;

  instr_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign count_inc = count + ONE_C;
  assign full      = (count == DEPTH_C);
  assign in_ready  = (state == S_IDLE) && !full && !clear;
  assign accept    = in_valid && in_ready;

  // imem_wdata doubles as the stored copy of the last word for readback, so
  // it and imem_addr hold their values after the write strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      err_illegal <= 1'b0;
    end else if (clear) begin
      state       <= S_IDLE;
      count       <= '0;
      imem_we     <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (packed_legal) begin
              state      <= S_WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= count[ADDR_W-1:0];
              imem_wdata <= packed_word;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          imem_we <= 1'b0;
          count   <= count_inc;
`ifdef ENCODER_READBACK_EN
          state   <= S_RB_ADDR;
`else
          state   <= (count_inc == DEPTH_C) ? S_FULL : S_IDLE;
`endif
        end
`ifdef ENCODER_READBACK_EN
        S_RB_ADDR: begin
          state <= S_RB_CMP;
        end
        S_RB_CMP: begin
          state <= full ? S_FULL : S_IDLE;
        end
`endif
        S_FULL: begin
          state <= S_FULL;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ENCODER_READBACK_EN
  // Read data for the written address arrives during RB_CMP (sync memory).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_mismatch <= 1'b0;
    end else if (clear) begin
      err_mismatch <= 1'b0;
    end else if (state == S_RB_CMP && imem_rdata != imem_wdata) begin
      err_mismatch <= 1'b1;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata;
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed cases plus a random
// stream, compared every cycle against a transaction-level reference model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
`ifdef ENCODER_READBACK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs1;
  logic [2:0]        in_rs2;
  logic [8:0]        in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic [15:0]       imem_rdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_illegal;
  logic              err_mismatch;

  int total;
  int bad;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_rdata   (imem_rdata),
    .count        (count),
    .full         (full),
    .err_illegal  (err_illegal),
    .err_mismatch (err_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with a synchronous read port; corrupt flips read bits.
  logic [15:0] mem [2**ADDR_W];
  logic [15:0] corrupt;
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'h0;
    imem_rdata = 16'h0;
  end
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    imem_rdata <= mem[imem_addr] ^ corrupt;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding straight from the format table.
  function automatic void encode(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                 input logic [2:0] rs2, input logic [8:0] imm,
                                 output logic [15:0] w, output bit ok);
    ok = 1'b1;
    w  = 16'h0;
    case (op)
      4'd2, 4'd4, 4'd6, 4'd7: w = {op, rd, rs1, rs2, 3'b000};
      4'd3, 4'd8, 4'd9: begin
        w  = {op, rd, rs1, imm[5:0]};
        ok = (imm[5:0] != 6'd0);
      end
      4'd0, 4'd1, 4'd5: w = {op, rd, imm[6:0], rs1[1:0]};
      4'd10, 4'd11:     w = {op, rd, imm};
      default:          ok = 1'b0;
    endcase
  endfunction

  // Reference model: phase counts cycles since a legal accept (0 = idle).
  int          m_phase;
  int          m_count;
  bit          m_ill;
  bit          m_mm;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0] m_wdata;

  always @(posedge clk or posedge rst) begin
    logic [15:0] w;
    bit ok;
    if (rst) begin
      m_phase = 0; m_count = 0; m_ill = 0; m_mm = 0; m_addr = '0; m_wdata = 16'h0;
    end else if (clear) begin
      m_phase = 0; m_count = 0; m_ill = 0; m_mm = 0;
    end else if (m_phase == 0) begin
      if (in_valid && m_count < DEPTH) begin
        encode(in_opcode, in_rd, in_rs1, in_rs2, in_imm, w, ok);
        if (ok) begin
          m_phase = 1;
          m_addr  = ADDR_W'(m_count);
          m_wdata = w;
        end else begin
          m_ill = 1;
        end
      end
    end else begin
      if (m_phase == 1) m_count++;
      if (m_phase == 3 && imem_rdata != m_wdata) m_mm = 1;
      m_phase = (m_phase == LAT) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready", 32'(in_ready), 32'(m_phase == 0 && m_count < DEPTH && !clear));
      checkOutput("imem_we", 32'(imem_we), 32'(m_phase == 1));
      checkOutput("imem_addr", 32'(imem_addr), 32'(m_addr));
      checkOutput("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
      checkOutput("count", 32'(count), 32'(m_count));
      checkOutput("full", 32'(full), 32'(m_count == DEPTH));
      checkOutput("err_illegal", 32'(err_illegal), 32'(m_ill));
      checkOutput("err_mismatch", 32'(err_mismatch), 32'(m_mm));
    end
  end

  // Offers one instruction; returns at posedge+2 after the transfer edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic [8:0] imm, output bit accepted);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid  = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #2;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_timeout: got busy expected idle at %0t", $time);
    end
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(posedge clk);
    #2;
    clear = 1'b0;
    #1;
  endtask

  initial begin
    bit acc;
    int nacc;
    logic [15:0] w;
    bit ok;
    total = 0; bad = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; corrupt = 16'h0;
    in_opcode = 4'h0; in_rd = 3'h0; in_rs1 = 3'h0; in_rs2 = 3'h0; in_imm = 9'h0;

    encode(4'b0010, 3'd1, 3'd2, 3'd3, 9'h0, w, ok);
    checkOutput("model_add", 32'(w), 32'h2298);
    encode(4'b0000, 3'd5, 3'd2, 3'd0, 9'h02A, w, ok);
    checkOutput("model_lw", 32'(w), 32'h0AAA);
    encode(4'b0011, 3'd1, 3'd1, 3'd0, 9'h1C0, w, ok);
    checkOutput("model_addi_nz0", 32'(ok), 32'h0);

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(in_ready), 32'h1);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_we", 32'(imem_we), 32'h0);

    applyStimulus(4'b0010, 3'd1, 3'd2, 3'd3, 9'h0, acc);
    checkOutput("add_acc", 32'(acc), 32'h1);
    checkOutput("add_we", 32'(imem_we), 32'h1);
    checkOutput("add_addr", 32'(imem_addr), 32'h0);
    checkOutput("add_wdata", 32'(imem_wdata), 32'h2298);
    waitIdle();
    checkOutput("add_count", 32'(count), 32'h1);

    applyStimulus(4'b0000, 3'd5, 3'd2, 3'd0, 9'h02A, acc);
    checkOutput("lw_addr", 32'(imem_addr), 32'h1);
    checkOutput("lw_wdata", 32'(imem_wdata), 32'h0AAA);
    waitIdle();

    applyStimulus(4'b0011, 3'd1, 3'd1, 3'd0, 9'h1C0, acc);
    checkOutput("addi0_acc", 32'(acc), 32'h1);
    checkOutput("addi0_we", 32'(imem_we), 32'h0);
    checkOutput("addi0_err", 32'(err_illegal), 32'h1);
    checkOutput("addi0_count", 32'(count), 32'h2);

    applyStimulus(4'b1110, 3'd7, 3'd7, 3'd7, 9'h1FF, acc);
    checkOutput("op14_acc", 32'(acc), 32'h1);
    checkOutput("op14_we", 32'(imem_we), 32'h0);

    applyStimulus(4'b1010, 3'd0, 3'd0, 3'd0, 9'h1FF, acc);
    checkOutput("br_addr", 32'(imem_addr), 32'h2);
    checkOutput("br_wdata", 32'(imem_wdata), 32'hA1FF);
    waitIdle();
    checkOutput("br_count", 32'(count), 32'h3);

    pulseClear();
    checkOutput("clr_count", 32'(count), 32'h0);
    checkOutput("clr_err", 32'(err_illegal), 32'h0);
    checkOutput("clr_ready", 32'(in_ready), 32'h1);

    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 3'(k), 3'd1, 3'd2, 9'h0, acc);
      if (acc) nacc++;
    end
    checkOutput("full_writes", 32'(nacc), 32'd4);
    checkOutput("full_flag", 32'(full), 32'h1);
    checkOutput("full_ready", 32'(in_ready), 32'h0);
    checkOutput("full_count", 32'(count), 32'h4);
    pulseClear();
    checkOutput("full_clr_count", 32'(count), 32'h0);
    checkOutput("full_clr_flag", 32'(full), 32'h0);
    checkOutput("full_clr_ready", 32'(in_ready), 32'h1);

    applyStimulus(4'b0110, 3'd3, 3'd4, 3'd5, 9'h0, acc);
    rst = 1'b1;
    #1;
    checkOutput("rstw_we", 32'(imem_we), 32'h0);
    checkOutput("rstw_addr", 32'(imem_addr), 32'h0);
    checkOutput("rstw_wdata", 32'(imem_wdata), 32'h0);
    checkOutput("rstw_count", 32'(count), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstw_ready", 32'(in_ready), 32'h1);

    applyStimulus(4'b0111, 3'd2, 3'd2, 3'd2, 9'h0, acc);
    waitIdle();
    in_opcode = 4'b0010; in_valid = 1'b1; clear = 1'b1;
    #1;
    checkOutput("clrv_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #2;
    in_valid = 1'b0; clear = 1'b0;
    #1;
    checkOutput("clrv_we", 32'(imem_we), 32'h0);
    checkOutput("clrv_count", 32'(count), 32'h0);

`ifdef ENCODER_READBACK_EN
    applyStimulus(4'b1000, 3'd1, 3'd2, 3'd0, 9'h005, acc);
    waitIdle();
    checkOutput("rb_match", 32'(err_mismatch), 32'h0);
    corrupt = 16'h0100;
    applyStimulus(4'b1001, 3'd1, 3'd2, 3'd0, 9'h006, acc);
    waitIdle();
    checkOutput("rb_mismatch", 32'(err_mismatch), 32'h1);
    corrupt = 16'h0;
    pulseClear();
`endif

    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_opcode = ($urandom_range(7) == 0) ? 4'(12 + $urandom_range(3)) : 4'($urandom_range(11));
      in_rd     = 3'($urandom);
      in_rs1    = 3'($urandom);
      in_rs2    = 3'($urandom);
      in_imm    = ($urandom_range(3) == 0) ? {3'($urandom), 6'd0} : 9'($urandom);
      clear     = ($urandom_range(29) == 0);
      corrupt   = ($urandom_range(5) == 0) ? 16'($urandom) : 16'h0;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0; corrupt = 16'h0;
    pulseClear();
    @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
